// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan controller: time-shares one hex decoder across DIGITS
// common-anode digits with a blanking gap, and double-buffers display data per frame.
module disp_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         hexs,
    input  logic [DIGITS-1:0]           points,
    input  logic [DIGITS-1:0]           les,
    output logic [3:0]                  hex,
    output logic                        point,
    output logic                        LE,
    output logic [DIGITS-1:0]           an,
    output logic [$clog2(DIGITS)-1:0]   digit,
    output logic                        frame_done,
    output logic                        upd_pending
);

    localparam int DIG_W = $clog2(DIGITS);
    localparam int MAXC  = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    phase_t                 r_phase;
    phase_t                 w_phase_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [DIG_W-1:0]       r_digit;
    logic [DIG_W-1:0]       w_digit_nxt;
    logic                   w_wrap;

    logic [4*DIGITS-1:0]    r_act_hex;
    logic [DIGITS-1:0]      r_act_pts;
    logic [DIGITS-1:0]      r_act_les;
    logic [4*DIGITS-1:0]    r_pend_hex;
    logic [DIGITS-1:0]      r_pend_pts;
    logic [DIGITS-1:0]      r_pend_les;
    logic                   r_pend_valid;

    logic [3:0]             w_hex;
    logic                   w_point;
    logic                   w_le;
    logic [DIGITS-1:0]      w_an;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= BLANK;
            r_cnt   <= '0;
            r_digit <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    // Outputs depend only on registered state; a zero-length BLANK is skipped on the next edge.
    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_digit_nxt = r_digit;
        w_wrap      = 1'b0;
        w_an        = '1;
        w_le        = 1'b1;
        w_hex       = 4'h0;
        w_point     = 1'b0;
        case (r_phase)
            BLANK: begin
                if (BLANK_CYC == 0 || r_cnt == BLANK_LAST) begin
                    w_phase_nxt = SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            SHOW: begin
                w_an[r_digit] = 1'b0;
                w_hex         = r_act_hex[{r_digit, 2'b00} +: 4];
                w_point       = r_act_pts[r_digit];
                w_le          = r_act_les[r_digit];
                if (r_cnt == SHOW_LAST) begin
                    w_cnt_nxt   = '0;
                    w_phase_nxt = (BLANK_CYC == 0) ? SHOW : BLANK;
                    if (r_digit == DIG_LAST) begin
                        w_digit_nxt = '0;
                        w_wrap      = 1'b1;
                    end else begin
                        w_digit_nxt = r_digit + DIG_W'(1);
                    end
                end
            end
            default: begin
                w_phase_nxt = BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A load landing on the wrap edge bypasses pending so the new frame uses it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_hex    <= '0;
            r_act_pts    <= '0;
            r_act_les    <= '0;
            r_pend_hex   <= '0;
            r_pend_pts   <= '0;
            r_pend_les   <= '0;
            r_pend_valid <= 1'b0;
        end else if (load && w_wrap) begin
            r_act_hex    <= hexs;
            r_act_pts    <= points;
            r_act_les    <= les;
            r_pend_valid <= 1'b0;
        end else if (load) begin
            r_pend_hex   <= hexs;
            r_pend_pts   <= points;
            r_pend_les   <= les;
            r_pend_valid <= 1'b1;
        end else if (w_wrap && r_pend_valid) begin
            r_act_hex    <= r_pend_hex;
            r_act_pts    <= r_pend_pts;
            r_act_les    <= r_pend_les;
            r_pend_valid <= 1'b0;
        end
    end

    assign hex         = w_hex;
    assign point       = w_point;
    assign LE          = w_le;
    assign an          = w_an;
    assign digit       = r_digit;
    assign frame_done  = w_wrap;
    assign upd_pending = r_pend_valid;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: frame-position model plus directed literal checks.
module tb_disp_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int S      = 4;
    localparam int B      = 1;
    localparam int SLOT   = B + S;
    localparam int FRAME  = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  les;
    logic [3:0]  hex;
    logic        point;
    logic        LE;
    logic [3:0]  an;
    logic [1:0]  digit;
    logic        frame_done;
    logic        upd_pending;

    int n_tests = 0;
    int n_fail  = 0;

    disp_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(S), .BLANK_CYC(B)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .hexs(hexs), .points(points), .les(les),
        .hex(hex), .point(point), .LE(LE), .an(an), .digit(digit),
        .frame_done(frame_done), .upd_pending(upd_pending)
    );

    always #5 clk = ~clk;

    // Model: m_t is the number of edges since reset release; frame position follows arithmetically.
    int          m_t;
    logic [15:0] m_act_hex, m_pend_hex;
    logic [3:0]  m_act_pts, m_pend_pts, m_act_les, m_pend_les;
    logic        m_pv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0;
            m_act_hex <= '0; m_act_pts <= '0; m_act_les <= '0;
            m_pend_hex <= '0; m_pend_pts <= '0; m_pend_les <= '0;
            m_pv <= 1'b0;
        end else begin
            if (load) begin
                if ((m_t % FRAME) == FRAME - 1) begin
                    m_act_hex <= hexs; m_act_pts <= points; m_act_les <= les;
                    m_pv <= 1'b0;
                end else begin
                    m_pend_hex <= hexs; m_pend_pts <= points; m_pend_les <= les;
                    m_pv <= 1'b1;
                end
            end else if ((m_t % FRAME) == FRAME - 1 && m_pv) begin
                m_act_hex <= m_pend_hex; m_act_pts <= m_pend_pts; m_act_les <= m_pend_les;
                m_pv <= 1'b0;
            end
            m_t <= m_t + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
        end
    endtask

    task automatic check_model();
        int p, slot, w;
        logic [3:0] e_an, e_hex;
        logic e_le, e_pt;
        p    = m_t % FRAME;
        slot = p / SLOT;
        w    = p % SLOT;
        e_an = 4'hF; e_hex = 4'h0; e_le = 1'b1; e_pt = 1'b0;
        if (w >= B) begin
            e_an  = ~(4'b0001 << slot);
            e_hex = m_act_hex[slot*4 +: 4];
            e_pt  = m_act_pts[slot];
            e_le  = m_act_les[slot];
        end
        chk("model{an,LE,hex,point,digit,fd,upd}",
            {19'd0, an, LE, hex, point, digit, frame_done, upd_pending},
            {19'd0, e_an, e_le, e_hex, e_pt, 2'(slot), (p == FRAME - 1), m_pv});
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int tgt);
        int g;
        g = 0;
        while (m_t != tgt && g < 200) begin
            step();
            g++;
        end
        if (m_t != tgt) chk("goto_timeout", m_t, tgt);
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
        load = 1'b1; hexs = h; points = p; les = l;
        step();
        load = 1'b0; hexs = $urandom; points = $urandom; les = $urandom;
    endtask

    task automatic chk_blank_lits(input string tag);
        chk({tag, "_an"}, an, 4'hF);
        chk({tag, "_LE"}, LE, 1);
        chk({tag, "_hex"}, hex, 0);
        chk({tag, "_point"}, point, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_upd"}, upd_pending, 0);
        chk({tag, "_digit"}, digit, 0);
    endtask

    initial begin
        rst_n = 1'b1; load = 1'b0; hexs = '0; points = '0; les = '0;
        #2 rst_n = 1'b0;
        #1 chk_blank_lits("reset");
        step(); step();
        rst_n = 1'b1;

        // Basic scan: 1234 loaded at t=0, shown in frame starting t=20
        do_load(16'h1234, 4'b0001, 4'b0000);
        chk("upd_after_load", upd_pending, 1);
        goto(19); chk("fd_first_wrap", frame_done, 1);
        goto(21); chk("d0_hex", hex, 4'h4); chk("d0_an", an, 4'b1110);
        chk("d0_point", point, 1); chk("d0_LE", LE, 0);
        goto(25); chk("gap_an", an, 4'b1111); chk("gap_LE", LE, 1);
        goto(26); chk("d1_hex", hex, 4'h3); chk("d1_point", point, 0);
        goto(36); chk("d3_hex", hex, 4'h1); chk("d3_an", an, 4'b0111);
        goto(39); chk("fd_second_wrap", frame_done, 1);

        // Double load: newest data wins
        goto(42); do_load(16'hAAAA, 4'b0000, 4'b0000);
        goto(50); do_load(16'h5555, 4'b0000, 4'b0000);
        goto(59); chk("dbl_upd_before_wrap", upd_pending, 1);
        goto(60); chk("dbl_upd_after_wrap", upd_pending, 0);
        goto(61); chk("dbl_d0_hex", hex, 4'h5);
        goto(71); chk("dbl_d2_hex", hex, 4'h5);

        // Load coincident with frame_done goes straight to active
        goto(79); chk("wrap_fd", frame_done, 1);
        do_load(16'hBEEF, 4'b0000, 4'b0000);
        chk("wrap_upd", upd_pending, 0);
        goto(81); chk("wrap_d0", hex, 4'hF);
        goto(86); chk("wrap_d1", hex, 4'hE);
        goto(91); chk("wrap_d2", hex, 4'hE);
        goto(96); chk("wrap_d3", hex, 4'hB);

        // Per-digit blank on digit 2
        goto(97); do_load(16'h1234, 4'b0000, 4'b0100);
        goto(106); chk("les_d1_LE", LE, 0); chk("les_d1_an", an, 4'b1101);
        goto(111); chk("les_d2_LE", LE, 1); chk("les_d2_an", an, 4'b1011);

        // Reset during SHOW of digit 2
        goto(112);
        #2 rst_n = 1'b0;
        #1 chk_blank_lits("midreset");
        step(); step();
        rst_n = 1'b1;
        goto(1); chk("post_d0_hex", hex, 0); chk("post_d0_an", an, 4'b1110);
        chk("post_d0_LE", LE, 0);
        goto(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
